// File: rtl/shift_arbiter_if.sv
// Handshake bundle between two byte requesters, the shift arbiter and the word consumer.
// The slave modport is the arbiter's view; the master modport drives requests and consumes words.
interface shift_arbiter_if;
    logic        a_valid;
    logic [7:0]  a_data;
    logic        a_ready;
    logic        b_valid;
    logic [7:0]  b_data;
    logic        b_ready;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_src;
    logic        word_ready;
    logic        abort;
    logic        busy;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, word_ready,
        output a_ready, b_ready, word_valid, word_data, word_src, abort, busy
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, word_ready,
        input  a_ready, b_ready, word_valid, word_data, word_src, abort, busy
    );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter that packs four bytes from one of two requesters into a 32-bit word.
// Define SHIFT_ARB_WATCHDOG_EN to abort a grant after TIMEOUT stalled COLLECT cycles.
module shift_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           reset,
    shift_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] word_data;
    logic [31:0] word_data_next;
    logic [2:0]  count;
    logic [2:0]  count_next;
    logic        word_src;
    logic        word_src_next;
    logic        last_winner;
    logic        last_winner_next;
    logic        grant;
    logic        granted_valid;
    logic [7:0]  granted_data;
    logic        accept;
    logic        timeout_hit;

    generate
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
            $error("shift_arbiter: TIMEOUT must be within 1..255");
        end
    endgenerate

    // On a tie the requester that did not win the previous word is granted.
    assign grant         = (bus.a_valid && bus.b_valid) ? ~last_winner : bus.b_valid;
    assign granted_valid = word_src ? bus.b_valid : bus.a_valid;
    assign granted_data  = word_src ? bus.b_data  : bus.a_data;
    assign accept        = (state == COLLECT) && granted_valid;

`ifdef SHIFT_ARB_WATCHDOG_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wd_count;
    logic [7:0] wd_count_next;

    assign timeout_hit = (state == COLLECT) && !granted_valid && (wd_count == WD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_count <= 8'd0;
        end else begin
            wd_count <= wd_count_next;
        end
    end

    // Counts only stalled COLLECT cycles; any other cycle leaves it at zero.
    always_comb begin
        wd_count_next = 8'd0;
        if (state == COLLECT && !granted_valid && !timeout_hit) begin
            wd_count_next = wd_count + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            word_data   <= 32'd0;
            count       <= 3'd0;
            word_src    <= 1'b0;
            last_winner <= 1'b1;
        end else begin
            state       <= state_next;
            word_data   <= word_data_next;
            count       <= count_next;
            word_src    <= word_src_next;
            last_winner <= last_winner_next;
        end
    end

    always_comb begin
        state_next       = state;
        word_data_next   = word_data;
        count_next       = count;
        word_src_next    = word_src;
        last_winner_next = last_winner;
        case (state)
            IDLE: begin
                if (bus.a_valid || bus.b_valid) begin
                    state_next     = COLLECT;
                    word_src_next  = grant;
                    word_data_next = 32'd0;
                    count_next     = 3'd0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    word_data_next = {word_data[23:0], granted_data};
                    count_next     = count + 3'd1;
                    if (count == 3'd3) begin
                        state_next = HOLD;
                    end
                end else if (timeout_hit) begin
                    state_next       = IDLE;
                    word_data_next   = 32'd0;
                    count_next       = 3'd0;
                    last_winner_next = word_src;
                end
            end
            HOLD: begin
                if (bus.word_ready) begin
                    state_next       = IDLE;
                    last_winner_next = word_src;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs are forced low while reset is held, whatever the state.
    assign bus.a_ready    = !reset && (state == COLLECT) && !word_src;
    assign bus.b_ready    = !reset && (state == COLLECT) && word_src;
    assign bus.word_valid = !reset && (state == HOLD);
    assign bus.busy       = !reset && (state != IDLE);
    assign bus.abort      = !reset && timeout_hit;
    assign bus.word_data  = word_data;
    assign bus.word_src   = word_src;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed, scoreboard-based bench for shift_arbiter (watchdog section follows SHIFT_ARB_WATCHDOG_EN).
module tb_shift_arbiter;

    logic clk = 1'b0;
    logic reset;

    shift_arbiter_if bus();

    shift_arbiter #(.TIMEOUT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        src;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] a_q[$];
    logic [7:0] b_q[$];

    int asserts = 0;
    int failures = 0;
    int cyc = 0;
    int hs_count = 0;
    int hs_cyc = 0;
    int abort_count = 0;
    int abort_cyc = 0;
    int last_a_acc = 0;
    int a_acc_count = 0;
    int start_cyc;
    int first_hs;
    int base;
    int acc0;

    logic word_ready_en = 1'b1;
    logic reset_drive = 1'b1;
    logic check_owner = 1'b1;

    logic        s_a_ready, s_b_ready, s_word_valid, s_word_src, s_abort, s_busy;
    logic [31:0] s_word_data;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Queues four bytes (MSB first) for one requester and optionally the word they should form.
    task automatic applyStimulus(input logic src, input logic [31:0] data, input logic push);
        for (int i = 3; i >= 0; i--) begin
            if (src) b_q.push_back(data[i*8 +: 8]);
            else     a_q.push_back(data[i*8 +: 8]);
        end
        if (push) exp_q.push_back('{src, data});
    endtask

    // One clock: drive at negedge, sample 1 ns later, score word handshakes, retire accepted bytes.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        reset          = reset_drive;
        bus.a_valid    = (a_q.size() > 0);
        bus.a_data     = (a_q.size() > 0) ? a_q[0] : 8'h00;
        bus.b_valid    = (b_q.size() > 0);
        bus.b_data     = (b_q.size() > 0) ? b_q[0] : 8'h00;
        bus.word_ready = word_ready_en;
        #1;
        s_a_ready    = bus.a_ready;
        s_b_ready    = bus.b_ready;
        s_word_valid = bus.word_valid;
        s_word_data  = bus.word_data;
        s_word_src   = bus.word_src;
        s_abort      = bus.abort;
        s_busy       = bus.busy;
        if (reset_drive) begin
            checkOutput("reset_ready", 32'({s_a_ready, s_b_ready}), 32'd0);
            checkOutput("reset_flags", 32'({s_word_valid, s_abort, s_busy}), 32'd0);
        end else begin
            checkOutput("ready_exclusive", 32'(s_a_ready & s_b_ready), 32'd0);
            if (check_owner && (s_a_ready || s_b_ready) && exp_q.size() > 0)
                checkOutput("ready_owner", 32'(s_b_ready), 32'(exp_q[0].src));
            if (s_abort) begin
                abort_count++;
                abort_cyc = cyc;
            end
            if (s_word_valid && word_ready_en) begin
                if (exp_q.size() == 0) begin
                    asserts++;
                    failures++;
                    $error("[TB] FAIL unexpected_word observed=0x%08h src=%0d expected=no word", s_word_data, s_word_src);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("word_data", s_word_data, e.data);
                    checkOutput("word_src", 32'(s_word_src), 32'(e.src));
                end
                hs_cyc = cyc;
                hs_count++;
            end
        end
        @(posedge clk);
        if (!reset_drive) begin
            if (bus.a_valid && s_a_ready) begin
                void'(a_q.pop_front());
                last_a_acc = cyc;
                a_acc_count++;
            end
            if (bus.b_valid && s_b_ready) void'(b_q.pop_front());
        end
        cyc++;
    endtask

    task automatic run_words(input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput("words_done", hs_count, target);
    endtask

    task automatic do_reset();
        reset_drive = 1'b1;
        tick();
        tick();
        reset_drive = 1'b0;
        a_q.delete();
        b_q.delete();
    endtask

    initial begin
        reset          = 1'b1;
        bus.a_valid    = 1'b0;
        bus.a_data     = 8'h00;
        bus.b_valid    = 1'b0;
        bus.b_data     = 8'h00;
        bus.word_ready = 1'b1;

        $display("[TB] reset state");
        do_reset();
        tick();
        checkOutput("idle_busy", 32'(s_busy), 32'd0);
        checkOutput("idle_word_valid", 32'(s_word_valid), 32'd0);
        checkOutput("idle_word_data", s_word_data, 32'd0);
        checkOutput("idle_word_src", 32'(s_word_src), 32'd0);

        $display("[TB] single A word and latency");
        applyStimulus(1'b0, 32'h11223344, 1'b1);
        start_cyc = cyc;
        base = hs_count;
        run_words(base + 1, 20);
        checkOutput("latency", hs_cyc - start_cyc, 5);

        $display("[TB] A and B contending");
        do_reset();
        applyStimulus(1'b0, 32'hA1A2A3A4, 1'b1);
        applyStimulus(1'b1, 32'hB1B2B3B4, 1'b1);
        applyStimulus(1'b0, 32'hC1C2C3C4, 1'b1);
        applyStimulus(1'b1, 32'hD1D2D3D4, 1'b1);
        base = hs_count;
        run_words(base + 1, 20);
        first_hs = hs_cyc;
        run_words(base + 4, 60);
        checkOutput("throughput", hs_cyc - first_hs, 18);

        $display("[TB] consumer back-pressure");
        word_ready_en = 1'b0;
        applyStimulus(1'b0, 32'h55667788, 1'b1);
        applyStimulus(1'b1, 32'h99AABBCC, 1'b1);
        base = hs_count;
        tick();
        for (int n = 0; n < 20 && !s_word_valid; n++) tick();
        checkOutput("hold_reached", 32'(s_word_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("hold_valid", 32'(s_word_valid), 32'd1);
            checkOutput("hold_data", s_word_data, 32'h55667788);
            checkOutput("hold_src", 32'(s_word_src), 32'd0);
            checkOutput("hold_ready", 32'({s_a_ready, s_b_ready}), 32'd0);
        end
        word_ready_en = 1'b1;
        run_words(base + 2, 40);

        $display("[TB] reset in the middle of a word");
        do_reset();
        applyStimulus(1'b0, 32'h01020304, 1'b0);
        acc0 = a_acc_count;
        for (int n = 0; n < 20 && (a_acc_count - acc0) < 3; n++) tick();
        checkOutput("three_bytes", a_acc_count - acc0, 3);
        reset_drive = 1'b1;
        tick();
        reset_drive = 1'b0;
        a_q.delete();
        tick();
        checkOutput("post_reset_busy", 32'(s_busy), 32'd0);
        checkOutput("post_reset_data", s_word_data, 32'd0);
        applyStimulus(1'b0, 32'hAABBCCDD, 1'b1);
        base = hs_count;
        run_words(base + 1, 20);

`ifdef SHIFT_ARB_WATCHDOG_EN
        $display("[TB] watchdog abort");
        do_reset();
        check_owner = 1'b0;
        abort_count = 0;
        acc0 = a_acc_count;
        a_q.push_back(8'h01);
        a_q.push_back(8'h02);
        tick();
        applyStimulus(1'b1, 32'hB0B1B2B3, 1'b1);
        base = hs_count;
        run_words(base + 1, 40);
        checkOutput("abort_count", abort_count, 1);
        checkOutput("abort_delay", abort_cyc - last_a_acc, 3);
        checkOutput("aborted_bytes", a_acc_count - acc0, 2);
        check_owner = 1'b1;
`else
        $display("[TB] indefinite stall without watchdog");
        do_reset();
        abort_count = 0;
        base = hs_count;
        a_q.push_back(8'h01);
        a_q.push_back(8'h02);
        repeat (22) tick();
        checkOutput("no_abort", abort_count, 0);
        checkOutput("stall_busy", 32'(s_busy), 32'd1);
        checkOutput("stall_no_word", hs_count - base, 0);
        a_q.push_back(8'h03);
        a_q.push_back(8'h04);
        exp_q.push_back('{1'b0, 32'h01020304});
        run_words(base + 1, 20);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, range 1..255: consecutive stalled COLLECT cycles before the watchdog abort fires.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port a_valid  input  1  requester A byte valid.
REQ-005 SHALL have port a_data  input  8  requester A byte.
REQ-006 SHALL have port a_ready  output  1  byte accepted from A this cycle when a_valid=1.
REQ-007 SHALL have port b_valid  input  1  requester B byte valid.
REQ-008 SHALL have port b_data  input  8  requester B byte.
REQ-009 SHALL have port b_ready  output  1  byte accepted from B this cycle when b_valid=1.
REQ-010 SHALL have port word_valid  output  1  assembled 32-bit word available.
REQ-011 SHALL have port word_data  output  32  assembly register; first accepted byte in [31:24], last in [7:0].
REQ-012 SHALL have port word_src  output  1  owner of current grant/word: 0=A, 1=B.
REQ-013 SHALL have port word_ready  input  1  consumer accepts word.
REQ-014 SHALL have port abort  output  1  one-cycle pulse: partial word discarded by watchdog.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM with states IDLE, COLLECT, HOLD, all transitions on rising clk.
REQ-017 IDLE: a_ready=b_ready=0, word_valid=0; if a_valid or b_valid, SHALL grant one requester, latch word_src, clear word_data and byte count to 0, go to COLLECT next cycle.
REQ-018 Arbitration SHALL be round-robin at word granularity: only one valid -> it wins; both valid -> requester other than last_winner wins; last_winner resets to B so A wins the first tie.
REQ-019 COLLECT: ready SHALL be 1 only for the granted requester, 0 for the other, combinationally from state and grant.
REQ-020 Each accepted byte (granted valid & ready) SHALL perform word_data <= {word_data[23:0], byte} and increment count.
REQ-021 On acceptance of the 4th byte (count 3->4) SHALL go to HOLD; word_valid=1 on the next cycle; first-valid-in-IDLE to word_valid minimum latency 5 cycles.
REQ-022 HOLD: word_valid=1, ready outputs 0, word_data and word_src stable until word_ready=1; on handshake SHALL set last_winner=word_src and go to IDLE.
REQ-023 Requests arriving during COLLECT/HOLD from the non-granted requester SHALL be held off (ready=0), never dropped or partially accepted.
REQ-024 Word throughput SHALL be at most one word per 6 cycles (IDLE 1 + COLLECT 4 + HOLD 1) with continuous valids and word_ready=1.
REQ-025 A HOLD->IDLE handshake and a new request in that same cycle SHALL be arbitrated only in the following IDLE cycle, using the updated last_winner.

Reset
REQ-026 reset SHALL take priority over all other inputs: state=IDLE, word_data=0, count=0, word_src=0, last_winner=B, watchdog count=0.
REQ-027 During and after reset: word_valid=0, a_ready=b_ready=0, abort=0, busy=0; reset mid-COLLECT or mid-HOLD SHALL discard the partial or held word without a handshake.

Configuration
REQ-028 Macro SHIFT_ARB_WATCHDOG_EN SHALL select the watchdog.
REQ-029 With SHIFT_ARB_WATCHDOG_EN defined: counter increments each COLLECT cycle with granted valid=0, clears on each accepted byte and on entry to COLLECT; upon reaching TIMEOUT SHALL pulse abort for one cycle, clear word_data and count, set last_winner to the aborted requester, and enter IDLE next cycle.
REQ-030 Without SHIFT_ARB_WATCHDOG_EN: no counter logic, abort tied 0, grant held in COLLECT indefinitely until 4 bytes accepted; TIMEOUT has no effect.
REQ-031 Watchdog SHALL never act in IDLE or HOLD.

Verification
REQ-032 A only, bytes 11,22,33,44 valid back-to-back, word_ready=1 -> word_valid 1 cycle after 4th byte, word_data=0x11223344, word_src=0.
REQ-033 A and B both valid continuously after reset -> word_src sequence 0,1,0,1; non-granted ready stays 0 throughout each word.
REQ-034 word_ready held 0 for 10 cycles in HOLD -> word_valid and word_data stable for 10 cycles, both ready outputs 0, next grant only after handshake.
REQ-035 Watchdog enabled, TIMEOUT=3, A sends 2 bytes then drops valid -> abort pulse exactly 3 stall cycles later, word_valid never asserted, a pending B wins next.
REQ-036 reset asserted after 3rd byte of a word -> next cycle busy=0, word_data=0; subsequent 4-byte A word assembles correctly as 0xAABBCCDD from AA,BB,CC,DD.
